// File: rtl/pipeline_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO for the E stage.
// Define MDU_MADD_EN to enable MADD/MADDU (ops 9/10); otherwise they act as NONE.
module pipeline_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             d_md_use,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAXC) + 1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;

`ifdef MDU_MADD_EN
    localparam logic MADD_EN = 1'b1;
`else
    localparam logic MADD_EN = 1'b0;
`endif

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_wr;
    logic             pend_acc;

    logic is_mul;
    logic is_div;
    logic is_madd;
    logic long_op;
    logic issue;
    logic sgn;

    assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
    assign is_madd = MADD_EN && ((op == OP_MADD) || (op == OP_MADDU));
    assign long_op = is_mul || is_div || is_madd;
    assign sgn     = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);

    assign busy      = (cnt != '0);
    assign issue     = start && !busy && long_op;
    assign stall_req = d_md_use && (busy || (start && long_op));
    assign rd_data   = (op == OP_MFHI) ? hi : lo;

    // Sign-extending to 2*WIDTH makes one unsigned multiplier serve both forms.
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;

    assign ext_a = {{WIDTH{sgn & rs_data[WIDTH-1]}}, rs_data};
    assign ext_b = {{WIDTH{sgn & rt_data[WIDTH-1]}}, rt_data};
    assign prod  = ext_a * ext_b;

    // Magnitude division; MIN / -1 falls out as quotient MIN, remainder 0.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    assign a_neg = sgn & rs_data[WIDTH-1];
    assign b_neg = sgn & rt_data[WIDTH-1];
    assign abs_a = a_neg ? -rs_data : rs_data;
    assign abs_b = b_neg ? -rt_data : rt_data;
    assign div_b = (abs_b == '0) ? WIDTH'(1) : abs_b;
    assign uq    = abs_a / div_b;
    assign ur    = abs_a % div_b;
    assign quo   = (a_neg ^ b_neg) ? -uq : uq;
    assign rem   = a_neg ? -ur : ur;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            pend_hi  <= '0;
            pend_lo  <= '0;
            pend_wr  <= 1'b0;
            pend_acc <= 1'b0;
        end else if (issue) begin
            cnt      <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_acc <= is_madd;
            pend_wr  <= !(is_div && (rt_data == '0));
            pend_hi  <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
            pend_lo  <= is_div ? quo : prod[WIDTH-1:0];
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if ((cnt == CNT_W'(1)) && pend_wr) begin
                if (pend_acc)
                    {hi, lo} <= {hi, lo} + {pend_hi, pend_lo};
                else
                    {hi, lo} <= {pend_hi, pend_lo};
            end
        end else if (start && (op == OP_MTHI)) begin
            hi <= rs_data;
        end else if (start && (op == OP_MTLO)) begin
            lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_pipeline_mdu.sv
// Bench for pipeline_mdu: directed vector table, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_pipeline_mdu;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        d_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    pipeline_mdu #(
        .WIDTH      (32),
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .d_md_use (d_md_use),
        .busy     (busy),
        .stall_req(stall_req),
        .hi       (hi),
        .lo       (lo),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t tbl[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_long(input logic [3:0] o, input logic [31:0] a,
                            input logic [31:0] b, output int n);
        start = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        step();
        start = 1'b0;
        op = 4'd0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
    endtask

    function automatic int exp_cyc(input logic [3:0] o);
        if (o == 4'd1 || o == 4'd2) return 5;
        if (o == 4'd3 || o == 4'd4) return 10;
        if ((o == 4'd9 || o == 4'd10) && MADD_EN) return 5;
        return 0;
    endfunction

    // Reference: 64-bit integer arithmetic on the architectural operands.
    function automatic void model_op(input logic [3:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        logic [63:0] r;
        longint      q;
        longint      m;
        case (o)
            4'd1: begin
                r = 64'(longint'($signed(a)) * longint'($signed(b)));
                {m_hi, m_lo} = r;
            end
            4'd2: begin
                r = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = r;
            end
            4'd3: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                m = longint'($signed(a)) % longint'($signed(b));
                m_lo = q[31:0];
                m_hi = m[31:0];
            end
            4'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            4'd9: if (MADD_EN) begin
                r = 64'(longint'($signed(a)) * longint'($signed(b)));
                {m_hi, m_lo} = {m_hi, m_lo} + r;
            end
            4'd10: if (MADD_EN) begin
                r = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = {m_hi, m_lo} + r;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        tbl[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        tbl[1] = '{4'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        tbl[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        tbl[3] = '{4'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        tbl[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10};

        reset = 1'b1;
        start = 1'b0;
        op = 4'd0;
        rs_data = '0;
        rt_data = '0;
        d_md_use = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_long(tbl[i].op, tbl[i].rs, tbl[i].rt, n);
            chk($sformatf("vec%0d_cycles", i), 32'(n), 32'(tbl[i].cyc));
            chk($sformatf("vec%0d_hi", i), hi, tbl[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, tbl[i].lo);
        end

        start = 1'b1;
        op = 4'd7;
        rs_data = 32'h1234;
        step();
        op = 4'd5;
        rs_data = 32'h0;
        #1;
        chk("mthi_hi", hi, 32'h1234);
        chk("mfhi_rd", rd_data, 32'h1234);
        op = 4'd6;
        #1;
        chk("mflo_rd", rd_data, 32'h8000_0000);
        step();
        start = 1'b0;
        chk("mf_no_change_hi", hi, 32'h1234);

        // Stall request, second start while busy, MTLO while busy.
        start = 1'b1;
        op = 4'd1;
        rs_data = 32'hFFFF_FFFE;
        rt_data = 32'd3;
        d_md_use = 1'b1;
        #1;
        chk("stall_issue", 32'(stall_req), 32'd1);
        step();
        n = 0;
        if (busy) n++;
        chk("stall_busy_use", 32'(stall_req), 32'd0 + 32'(1'b1 & d_md_use));
        d_md_use = 1'b0;
        #1;
        chk("stall_busy_nouse", 32'(stall_req), 32'd0);
        op = 4'd3;
        rs_data = 32'd100;
        rt_data = 32'd7;
        step();
        if (busy) n++;
        op = 4'd8;
        rs_data = 32'hDEAD;
        step();
        start = 1'b0;
        op = 4'd0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk("restart_cycles", 32'(n), 32'd5);
        chk("restart_hi", hi, 32'hFFFF_FFFF);
        chk("restart_lo", lo, 32'hFFFF_FFFA);

        // Reset in the middle of a multiply.
        start = 1'b1;
        op = 4'd1;
        rs_data = 32'd7;
        rt_data = 32'd9;
        step();
        start = 1'b0;
        op = 4'd0;
        step();
        step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (10) step();
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        // MADD: accumulate when enabled, inert otherwise.
        start = 1'b1;
        op = 4'd8;
        rs_data = 32'd5;
        step();
        op = 4'd9;
        rs_data = 32'd2;
        rt_data = 32'd3;
        d_md_use = 1'b1;
        #1;
        chk("madd_stall", 32'(stall_req), 32'(MADD_EN));
        d_md_use = 1'b0;
        run_long(4'd9, 32'd2, 32'd3, n);
        chk("madd_cycles", 32'(n), MADD_EN ? 32'd5 : 32'd0);
        chk("madd_hi", hi, 32'd0);
        chk("madd_lo", lo, MADD_EN ? 32'd11 : 32'd5);

        m_hi = hi;
        m_lo = lo;
        if (hi !== 32'd0 || lo !== (MADD_EN ? 32'd11 : 32'd5)) begin
            m_hi = MADD_EN ? 32'd0 : 32'd0;
            m_lo = MADD_EN ? 32'd11 : 32'd5;
        end

        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(1, 10));
            a = rnd_operand();
            b = rnd_operand();
            if (o == 4'd5 || o == 4'd6) begin
                start = 1'b1;
                op = o;
                #1;
                chk($sformatf("rnd%0d_mf", i), rd_data, (o == 4'd5) ? m_hi : m_lo);
                step();
                start = 1'b0;
            end else if (o == 4'd7 || o == 4'd8) begin
                start = 1'b1;
                op = o;
                rs_data = a;
                step();
                start = 1'b0;
                model_op(o, a, b);
            end else begin
                run_long(o, a, b, n);
                chk($sformatf("rnd%0d_cycles", i), 32'(n), 32'(exp_cyc(o)));
                model_op(o, a, b);
            end
            chk($sformatf("rnd%0d_op%0d_hi", i, o), hi, m_hi);
            chk($sformatf("rnd%0d_op%0d_lo", i, o), lo, m_lo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
